mi_switch_2x2_router: RTL
=========================

# mi_switch_2x2_router

Self-routing 2x2 switch element for the multistage interconnect network. It replaces externally driven `select` with per-packet routing: each input word carries its destination bit, and the block arbitrates when both inputs want the same output. It buffers each output behind a valid/ready handshake. Stages of the network are built by chaining these elements, with each stage using a different routing bit.

## Interface
- `WIDTH`, 64: payload width in bits, routing bit included.
- `ROUTE_BIT`, 0: index of the payload bit used as destination; 0 selects left_out, 1 selects right_out. Legal range is 0..WIDTH-1.
- `clk`  input  1  clock; all state updates on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `left_in`  input  WIDTH  left input payload.
- `left_in_valid`  input  1  left payload present.
- `left_in_ready`  output  1  left payload accepted this cycle.
- `right_in`  input  WIDTH  right input payload.
- `right_in_valid`  input  1  right payload present.
- `right_in_ready`  output  1  right payload accepted this cycle.
- `left_out`  output  WIDTH  left output payload.
- `left_out_valid`  output  1  left output holds a word.
- `left_out_ready`  input  1  downstream takes left word.
- `right_out`  output  WIDTH  right output payload.
- `right_out_valid`  output  1  right output holds a word.
- `right_out_ready`  input  1  downstream takes right word.

## Operation
- Destination: `dest_x = x_in[ROUTE_BIT]` for x in {left, right}. The payload is forwarded unmodified, routing bit included.
- Per-output accept condition `acc_o`:
  - Default build: `!o_out_valid || o_out_ready`.
  - With the FIFO build: `count_o < 2`.
- Request: input x requests output o when `x_in_valid && dest_x == o`.
- Grant to output o:
  - Requires `acc_o`.
  - If a single input requests o, that input is granted.
  - If both inputs request o, the input named by `prio_o` is granted (0 = left, 1 = right).
- Priority update: after a contested grant, `prio_o` flips to the losing input. An uncontested grant leaves `prio_o` unchanged.
- Readiness: `x_in_ready` equals the grant for input x.
  - It is combinational from the valids, payload routing bits and accept terms.
  - Valid must never depend on ready upstream.
- Each input targets exactly one output, so at most one grant per input per cycle. Straight and cross traffic with no conflict both forward two words per cycle.
- Output register, default build:
  - On grant, `o_out <= granted payload` and `o_out_valid <= 1`.
  - Otherwise, if `o_out_ready`, then `o_out_valid <= 0`.
  - `o_out` holds its value when not loaded.
- Reset (`rst` high at a clock edge), which also aborts any transfer in flight mid-stream:
  - all `*_out_valid` = 0;
  - `left_out` = `right_out` = 0;
  - `prio_o` = 0;
  - FIFO counts and pointers = 0.
- While `rst` is high, both `*_in_ready` are forced to 0.

## Timing
- Latency: 1 cycle. A word accepted at edge N is valid on its output after edge N.
- Throughput: one word per output per cycle while downstream holds ready high.
- Conflict: each output sustains one word per cycle, so each contending input gets 50%.
- Backpressure, default build: `o_out_valid && !o_out_ready` gives `acc_o = 0`, so no grant to o. The output word and valid stay stable until taken.
- Simultaneous pop and load in the same cycle is legal in the default build: the old word leaves and the new word appears after the edge.
- Deassertion of `rst`: inputs may be granted in the first cycle with `rst` low.

## Configuration
- `MI_SWITCH_OUT_FIFO_EN` undefined: single output register per output, with `acc_o` as in Operation.
- `MI_SWITCH_OUT_FIFO_EN` defined: each output is a 2-entry FIFO.
  - Head drives `o_out` and `o_out_valid = count_o != 0`.
  - `acc_o = count_o < 2` is purely registered, which removes the `o_out_ready` to `x_in_ready` combinational path.
  - Push and pop in the same cycle at count 1 keeps count at 1.
  - At count 2, a pop frees space only from the next cycle, so no push is accepted that cycle.
  - Latency stays at 1 cycle.
  - With out_ready held at 0, two words are absorbed before in_ready drops.

## Test plan
- Reset: hold `rst` 2 cycles with both inputs valid -> both in_ready stay 0, and outputs read valid 0, data 0.
- Straight/cross: left_in=0x10, right_in=0x21, both valid, ROUTE_BIT=0, out_ready=1 -> next cycle left_out=0x10 and right_out=0x21. Then left_in=0x31, right_in=0x40 -> right_out=0x31, left_out=0x40.
- Conflict: both inputs valid for 4 cycles with dest 0, left=0xA0, right=0xB0, left_out_ready=1 -> left_out sequence 0xA0,0xB0,0xA0,0xB0, and the in_ready pattern alternates starting with left.
- Backpressure: left_out_ready=0 and left input streams 0x02,0x04,... -> default build: left_out=0x02 holds, and only one word is accepted. FIFO build: two words are accepted, then left_in_ready=0. Raising left_out_ready drains them in order.
- Mid-stream reset: assert `rst` for one cycle during conflict traffic -> valids drop to 0 the next cycle, and the first post-reset conflict is granted to left.
- Independence: left_out_ready=0 with left_out full, while right traffic continues -> right_out keeps one word per cycle, unaffected.

Source files
------------

// File: rtl/mi_switch_2x2_router_if.sv
// Valid/ready payload channel used for every port of the 2x2 switch element.
// master drives data/valid and samples ready; slave is the receiving side.
interface mi_switch_2x2_router_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input  ready);
    modport slave  (input  data, input  valid, output ready);
endinterface

// File: rtl/mi_switch_2x2_router.sv
// Self-routing 2x2 switch element for the multistage interconnect network.
// Each input word carries its destination in bit ROUTE_BIT (0 = left_out,
// 1 = right_out). When both inputs target the same output, a per-output
// priority bit picks the winner and then hands priority to the loser.
//
// Optional build macro MI_SWITCH_OUT_FIFO_EN: each output becomes a 2-entry
// FIFO whose accept term is purely registered, which cuts the combinational
// path from out ready back to in ready. Undefined: a single output register.
module mi_switch_2x2_router #(
    parameter int WIDTH     = 64,
    parameter int ROUTE_BIT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    mi_switch_2x2_router_if.slave  left_in,
    mi_switch_2x2_router_if.slave  right_in,
    mi_switch_2x2_router_if.master left_out,
    mi_switch_2x2_router_if.master right_out
);
    // All 2-bit vectors below are indexed by output: 0 = left_out, 1 = right_out.
    logic             dest_l, dest_r;
    logic [1:0]       req_l, req_r;
    logic [1:0]       acc, prio, contest;
    logic [1:0]       gnt_l, gnt_r, push;
    logic [1:0]       out_vld, out_rdy;
    logic [WIDTH-1:0] push_data [2];
    logic [WIDTH-1:0] out_data  [2];

    assign dest_l  = left_in.data[ROUTE_BIT];
    assign dest_r  = right_in.data[ROUTE_BIT];
    assign req_l   = {left_in.valid  &  dest_l, left_in.valid  & ~dest_l};
    assign req_r   = {right_in.valid &  dest_r, right_in.valid & ~dest_r};
    assign out_rdy = {right_out.ready, left_out.ready};

    // Arbitration: a lone requester wins; on contention prio names the winner.
    always_comb begin
        gnt_l   = '0;
        gnt_r   = '0;
        contest = '0;
        for (int o = 0; o < 2; o++) begin
            contest[o] = req_l[o] & req_r[o];
            if (!rst && acc[o]) begin
                if (contest[o]) begin
                    gnt_l[o] = ~prio[o];
                    gnt_r[o] =  prio[o];
                end else begin
                    gnt_l[o] = req_l[o];
                    gnt_r[o] = req_r[o];
                end
            end
        end
    end

    // An input targets exactly one output, so OR-ing its grants is its ready.
    assign left_in.ready  = |gnt_l;
    assign right_in.ready = |gnt_r;
    assign push           = gnt_l | gnt_r;
    assign push_data[0]   = gnt_r[0] ? right_in.data : left_in.data;
    assign push_data[1]   = gnt_r[1] ? right_in.data : left_in.data;

    // Priority flips to the loser only after a contested grant.
    always_ff @(posedge clk) begin
        if (rst) prio <= '0;
        else     prio <= prio ^ (contest & push);
    end

    for (genvar o = 0; o < 2; o++) begin : g_out
`ifdef MI_SWITCH_OUT_FIFO_EN
        logic [WIDTH-1:0] mem [2];
        logic             wp, rp, pop;
        logic [1:0]       cnt;

        assign pop = (cnt != 2'd0) && out_rdy[o];

        // 2-entry FIFO; a pop at count 2 only frees space for the next cycle.
        always_ff @(posedge clk) begin
            if (rst) begin
                mem[0] <= '0;
                mem[1] <= '0;
                wp     <= 1'b0;
                rp     <= 1'b0;
                cnt    <= 2'd0;
            end else begin
                if (push[o]) begin
                    mem[wp] <= push_data[o];
                    wp      <= ~wp;
                end
                if (pop) rp <= ~rp;
                cnt <= cnt + {1'b0, push[o]} - {1'b0, pop};
            end
        end

        assign acc[o]      = ~cnt[1];
        assign out_vld[o]  = cnt != 2'd0;
        assign out_data[o] = mem[rp];
`else
        logic             vld_q;
        logic [WIDTH-1:0] data_q;

        // Single output register; load on grant, clear valid when taken.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q  <= 1'b0;
                data_q <= '0;
            end else if (push[o]) begin
                vld_q  <= 1'b1;
                data_q <= push_data[o];
            end else if (out_rdy[o]) begin
                vld_q  <= 1'b0;
            end
        end

        assign acc[o]      = !vld_q || out_rdy[o];
        assign out_vld[o]  = vld_q;
        assign out_data[o] = data_q;
`endif
    end

    assign left_out.data   = out_data[0];
    assign left_out.valid  = out_vld[0];
    assign right_out.data  = out_data[1];
    assign right_out.valid = out_vld[1];
endmodule
